srsystem_rx_frame: RTL and testbench

Parametrised serial reception engine, successor to the fixed 11-bit serial-in shift register of the SRSystem.
- Frame: start bit, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits.
- Oversamples rx against an external tick, validates start, parity and stop, and presents each word on a valid/ready parallel interface.
- Sits between the pad-side rx line and the SRSystem parallel consumer.

---
 rtl/srsystem_rx_pkg.sv | 26 ++
 rtl/srsystem_rx_sync.sv | 27 ++
 rtl/srsystem_rx_frame.sv | 211 +++++++++++++++++++++
 tb/tb_srsystem_rx_frame.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/srsystem_rx_pkg.sv
// Shared types and constants for the SRSystem serial receive path.
// Counter widths are derived from the instance parameters through the helper functions.
package srsystem_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

    // Widths of the oversample tick counter and of the data-bit index counter.
    function automatic int tick_cnt_w(input int oversample);
        return $clog2(oversample);
    endfunction

    function automatic int bit_idx_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/srsystem_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pad input.
// Both flops reset to the idle line level, so a reset never looks like a start bit.
module srsystem_rx_sync
    import srsystem_rx_pkg::*;
(
    input  logic rxclk,
    input  logic clr,
    input  logic rx_i,
    output logic rx_s_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge rxclk) begin
        if (clr) begin
            meta_q <= LINE_IDLE;
            sync_q <= LINE_IDLE;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
        end
    end

    assign rx_s_o = sync_q;

endmodule

// File: rtl/srsystem_rx_frame.sv
// Oversampling serial frame receiver: start, DATA_W bits LSB first, optional parity,
// STOP_BITS stop bits; each word is presented on a valid/ready parallel interface.
module srsystem_rx_frame
    import srsystem_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic              rxclk,
    input  logic              clr,
    input  logic              rx,
    input  logic              sample_tick,
    output logic [DATA_W-1:0] Q,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              perr,
    output logic              ferr,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = tick_cnt_w(OVERSAMPLE);
    localparam int IDX_W = bit_idx_w(DATA_W);

    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic             PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    logic rx_s;

    srsystem_rx_sync u_sync (
        .rxclk  (rxclk),
        .clr    (clr),
        .rx_i   (rx),
        .rx_s_o (rx_s)
    );

    rx_state_e         state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic [DATA_W-1:0] shift_q,     shift_d;
    logic              perr_pend_q, perr_pend_d;
    logic              ferr_pend_q, ferr_pend_d;
    logic              armed_q,     armed_d;
    logic              commit_q,    commit_d;
    logic [DATA_W-1:0] q_q,         q_d;
    logic              valid_q,     valid_d;
    logic              perr_q,      perr_d;
    logic              ferr_q,      ferr_d;
    logic              ovr_q,       ovr_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        armed_d     = armed_q;
        commit_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // After a break (final stop low) the line must return high before re-arming.
                if (rx_s) begin
                    armed_d = 1'b1;
                end
                if (sample_tick && armed_q && !rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d     = DATA;
                            idx_d       = '0;
                            perr_pend_d = 1'b0;
                            ferr_pend_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[DATA_W-1:1]};
                        if (idx_q == LAST_BIT) begin
                            idx_d   = '0;
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (sample_tick) begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d       = '0;
                        perr_pend_d = ((^shift_q) ^ rx_s) != PAR_MODE;
                        state_d     = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (sample_tick) begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d       = '0;
                        ferr_pend_d = ferr_pend_q | !rx_s;
                        if (idx_q == LAST_STOP) begin
                            idx_d    = '0;
                            state_d  = IDLE;
                            commit_d = 1'b1;
                            if (!rx_s) begin
                                armed_d = 1'b0;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output holding register: a commit into a full, unaccepted slot is dropped and flagged.
    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (commit_q) begin
            if (!valid_q || rx_ready) begin
                q_d     = shift_q;
                perr_d  = perr_pend_q;
                ferr_d  = ferr_pend_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge rxclk) begin
        if (clr) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            armed_q     <= 1'b0;
            commit_q    <= 1'b0;
            q_q         <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            armed_q     <= armed_d;
            commit_q    <= commit_d;
            q_q         <= q_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    always_ff @(posedge rxclk) begin
        shift_q <= shift_d;
    end

    assign Q        = q_q;
    assign rx_valid = valid_q;
    assign perr     = perr_q;
    assign ferr     = ferr_q;
    assign overrun  = ovr_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_srsystem_rx_frame.sv
// Bench for srsystem_rx_frame: a default 8E/O1 instance (A) and a 7-bit, no-parity, 2-stop instance (B).
// A frame-level scoreboard predicts each delivered word; directed checks pin literal values.
module tb_srsystem_rx_frame;

    localparam int OS_A = 16;
    localparam int OS_B = 8;

    logic       clk = 1'b0;
    logic       clr;
    logic       tick;
    logic       rx_a, rx_b;
    logic       rx_ready_a, rx_ready_b;
    logic [7:0] Q_a;
    logic [6:0] Q_b;
    logic       rx_valid_a, perr_a, ferr_a, overrun_a, busy_a;
    logic       rx_valid_b, perr_b, ferr_b, overrun_b, busy_b;

    always #5 clk = ~clk;

    srsystem_rx_frame #(
        .DATA_W(8), .OVERSAMPLE(OS_A), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
    ) dut_a (
        .rxclk(clk), .clr(clr), .rx(rx_a), .sample_tick(tick), .Q(Q_a),
        .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .perr(perr_a),
        .ferr(ferr_a), .overrun(overrun_a), .busy(busy_a)
    );

    srsystem_rx_frame #(
        .DATA_W(7), .OVERSAMPLE(OS_B), .PARITY_EN(0), .PARITY_ODD(1), .STOP_BITS(2)
    ) dut_b (
        .rxclk(clk), .clr(clr), .rx(rx_b), .sample_tick(tick), .Q(Q_b),
        .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .perr(perr_b),
        .ferr(ferr_b), .overrun(overrun_b), .busy(busy_b)
    );

    typedef struct {
        logic [7:0] q;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int checks   = 0;
    int failures = 0;
    int got_a    = 0;
    int got_b    = 0;
    logic [7:0] last_q_a, last_q_b;
    logic       last_perr_a, last_ferr_a, last_ferr_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Odd parity: data ones plus parity bit must be odd.
    function automatic logic model_perr(input logic [7:0] d, input logic p);
        int ones;
        ones = $countones(d) + int'(p);
        return (ones % 2) != 1;
    endfunction

    function automatic logic [15:0] frame_a(input logic [7:0] d, input logic p, input logic stp);
        return {5'b11111, stp, p, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame_b(input logic [6:0] d, input logic s1, input logic s2);
        return {6'b111111, s2, s1, d, 1'b0};
    endfunction

    task automatic send_frame(input int which, input logic [15:0] f, input int n);
        int os;
        os = (which == 0) ? OS_A : OS_B;
        for (int i = 0; i < n; i++) begin
            if (which == 0) rx_a = f[i];
            else            rx_b = f[i];
            repeat (os) @(posedge clk);
            #1;
            if (i == 4) check("busy_mid_frame", 32'((which == 0) ? busy_a : busy_b), 32'd1);
        end
        rx_a = 1'b1;
        rx_b = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d, input logic p, input logic stp, input bit deliver);
        exp_t e;
        e.q    = d;
        e.perr = model_perr(d, p);
        e.ferr = ~stp;
        if (deliver) exp_a.push_back(e);
        send_frame(0, frame_a(d, p, stp), 11);
        idle(40);
    endtask

    task automatic send_b(input logic [6:0] d, input logic s1, input logic s2);
        exp_t e;
        e.q    = {1'b0, d};
        e.perr = 1'b0;
        e.ferr = ~(s1 & s2);
        exp_b.push_back(e);
        send_frame(1, frame_b(d, s1, s2), 10);
        idle(30);
    endtask

    // Scoreboard: every cycle a word is presented it must match the oldest predicted frame.
    always @(negedge clk) begin
        if (!clr) begin
            if (rx_valid_a) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word_a: got Q=%0h expected no word", Q_a);
                end else begin
                    check("Q_a", 32'(Q_a), 32'(exp_a[0].q));
                    check("perr_a", 32'(perr_a), 32'(exp_a[0].perr));
                    check("ferr_a", 32'(ferr_a), 32'(exp_a[0].ferr));
                    last_q_a    = Q_a;
                    last_perr_a = perr_a;
                    last_ferr_a = ferr_a;
                    if (rx_ready_a) begin
                        void'(exp_a.pop_front());
                        got_a++;
                    end
                end
            end
            if (rx_valid_b) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word_b: got Q=%0h expected no word", Q_b);
                end else begin
                    check("Q_b", 32'(Q_b), 32'(exp_b[0].q));
                    check("perr_b", 32'(perr_b), 32'(exp_b[0].perr));
                    check("ferr_b", 32'(ferr_b), 32'(exp_b[0].ferr));
                    last_q_b    = {1'b0, Q_b};
                    last_ferr_b = ferr_b;
                    if (rx_ready_b) begin
                        void'(exp_b.pop_front());
                        got_b++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr        = 1'b1;
        tick       = 1'b1;
        rx_a       = 1'b1;
        rx_b       = 1'b1;
        rx_ready_a = 1'b1;
        rx_ready_b = 1'b1;
        idle(4);
        clr = 1'b0;

        check("rst_Q_a", 32'(Q_a), 32'd0);
        check("rst_valid_a", 32'(rx_valid_a), 32'd0);
        check("rst_flags_a", 32'({perr_a, ferr_a, overrun_a, busy_a}), 32'd0);
        check("rst_Q_b", 32'(Q_b), 32'd0);
        check("rst_flags_b", 32'({rx_valid_b, perr_b, ferr_b, overrun_b, busy_b}), 32'd0);
        idle(10);

        // Good frame 0xA5 with correct odd parity.
        send_a(8'hA5, 1'b1, 1'b1, 1'b1);
        check("a5_count", 32'(got_a), 32'd1);
        check("a5_Q", 32'(last_q_a), 32'h000000A5);
        check("a5_perr", 32'(last_perr_a), 32'd0);
        check("a5_ferr", 32'(last_ferr_a), 32'd0);
        check("a5_overrun", 32'(overrun_a), 32'd0);
        check("a5_busy_after", 32'(busy_a), 32'd0);
        check("a5_valid_after", 32'(rx_valid_a), 32'd0);

        // Same word with wrong parity bit.
        send_a(8'hA5, 1'b0, 1'b1, 1'b1);
        check("badpar_count", 32'(got_a), 32'd2);
        check("badpar_Q", 32'(last_q_a), 32'h000000A5);
        check("badpar_perr", 32'(last_perr_a), 32'd1);
        check("badpar_ferr", 32'(last_ferr_a), 32'd0);

        // Stop bit low: delivered with ferr, then a clean frame.
        send_a(8'h3C, 1'b1, 1'b0, 1'b1);
        check("ferr_count", 32'(got_a), 32'd3);
        check("ferr_Q", 32'(last_q_a), 32'h0000003C);
        check("ferr_flag", 32'(last_ferr_a), 32'd1);
        send_a(8'h81, 1'b1, 1'b1, 1'b1);
        check("after_ferr_count", 32'(got_a), 32'd4);
        check("after_ferr_Q", 32'(last_q_a), 32'h00000081);
        check("after_ferr_flag", 32'(last_ferr_a), 32'd0);

        // Short glitch: start detected, rejected at mid-bit.
        rx_a = 1'b0;
        idle(4);
        rx_a = 1'b1;
        idle(3);
        check("glitch_busy_start", 32'(busy_a), 32'd1);
        idle(40);
        check("glitch_busy_end", 32'(busy_a), 32'd0);
        check("glitch_no_word", 32'(got_a), 32'd4);
        check("glitch_no_valid", 32'(rx_valid_a), 32'd0);

        // Overrun: consumer stalled across two frames.
        rx_ready_a = 1'b0;
        send_a(8'h11, 1'b1, 1'b1, 1'b1);
        check("ovr_first_valid", 32'(rx_valid_a), 32'd1);
        check("ovr_first_flag", 32'(overrun_a), 32'd0);
        send_a(8'h22, 1'b1, 1'b1, 1'b0);
        check("ovr_Q_held", 32'(Q_a), 32'h00000011);
        check("ovr_valid", 32'(rx_valid_a), 32'd1);
        check("ovr_flag", 32'(overrun_a), 32'd1);
        rx_ready_a = 1'b1;
        idle(1);
        rx_ready_a = 1'b0;
        check("ovr_accept_valid", 32'(rx_valid_a), 32'd0);
        check("ovr_accept_flag", 32'(overrun_a), 32'd0);
        idle(20);
        check("ovr_count", 32'(got_a), 32'd5);
        rx_ready_a = 1'b1;

        // Instance B: 7 data bits, no parity, two stop bits.
        send_b(7'h55, 1'b1, 1'b1);
        check("b55_count", 32'(got_b), 32'd1);
        check("b55_Q", 32'(last_q_b), 32'h00000055);
        check("b55_ferr", 32'(last_ferr_b), 32'd0);

        // Abort mid-frame with clr.
        send_frame(1, frame_b(7'h7F, 1'b1, 1'b1), 5);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        check("clr_Q_b", 32'(Q_b), 32'd0);
        check("clr_flags_b", 32'({rx_valid_b, perr_b, ferr_b, overrun_b, busy_b}), 32'd0);
        idle(100);
        check("clr_no_partial", 32'(got_b), 32'd1);
        check("clr_idle_busy", 32'(busy_b), 32'd0);

        send_b(7'h2A, 1'b1, 1'b1);
        check("b2a_count", 32'(got_b), 32'd2);
        check("b2a_Q", 32'(last_q_b), 32'h0000002A);
        check("b2a_perr_const", 32'(perr_b), 32'd0);

        check("pending_a", 32'(exp_a.size()), 32'd0);
        check("pending_b", 32'(exp_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
